// File: rtl/rtc_timekeeper.sv
// -----------------------------------------------------------------------------
// rtc_timekeeper
// Time-of-day counter (hh:mm:ss, 24 h) used to timestamp lock events.
// A prescaler divides the system clock down to one-second ticks. Features:
// run/pause with the partial second preserved, validated time set,
// minute-resolution alarm, day-rollover pulse and a 12 h display view.
//
// Parameters:
//   CLK_FREQ_HZ   system clock cycles per second (>= 1); 1 = one second per
//                 enabled cycle
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; overrides every other input
//   run            1 = time advances, 0 = prescaler and time frozen
//   set_en         one-cycle request to load set_hours/minutes/seconds
//   set_hours      hours to load (0..23)
//   set_minutes    minutes to load (0..59)
//   set_seconds    seconds to load (0..59)
//   alarm_en       enables the alarm compare
//   alarm_hours    alarm hour (0..23)
//   alarm_minutes  alarm minute (0..59)
//   seconds        current seconds (0..59)
//   minutes        current minutes (0..59)
//   hours          current hours (0..23)
//   hours12        12 h view of hours (1..12)
//   pm             1 = PM in the 12 h view
//   sec_tick       one-cycle pulse, the seconds just advanced
//   day_tick       one-cycle pulse, 23:59:59 -> 00:00:00 wrap
//   alarm_hit      one-cycle pulse, a tick reached alarm_hours:alarm_minutes:00
//   set_err        one-cycle pulse, set_en carried out-of-range values
// -----------------------------------------------------------------------------
module rtc_timekeeper #(
    parameter int CLK_FREQ_HZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       set_en,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [3:0] hours12,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       set_err
);

    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         seconds_q, seconds_d;
    logic [5:0]         minutes_q, minutes_d;
    logic [4:0]         hours_q, hours_d;
    logic               sec_tick_q, sec_tick_d;
    logic               day_tick_q, day_tick_d;
    logic               alarm_hit_q, alarm_hit_d;
    logic               set_err_q, set_err_d;

    logic               tick_s;
    logic               set_valid_s;
    logic               alarm_range_s;
    logic [4:0]         hours_m12_s;

    // Next-state: set has priority over a coincident tick; counters compare at
    // their wrap value so no register ever holds an out-of-range value.
    always_comb begin
        tick_s        = run && (presc_q == PRESC_MAX);
        set_valid_s   = set_en && (set_hours < 5'd24) && (set_minutes < 6'd60)
                        && (set_seconds < 6'd60);
        alarm_range_s = (alarm_hours < 5'd24) && (alarm_minutes < 6'd60);

        presc_d     = presc_q;
        seconds_d   = seconds_q;
        minutes_d   = minutes_q;
        hours_d     = hours_q;
        sec_tick_d  = 1'b0;
        day_tick_d  = 1'b0;
        alarm_hit_d = 1'b0;
        set_err_d   = 1'b0;

        if (set_valid_s) begin
            // A valid set restarts the second from zero and never pulses.
            seconds_d = set_seconds;
            minutes_d = set_minutes;
            hours_d   = set_hours;
            presc_d   = '0;
        end else begin
            set_err_d = set_en;

            if (run) begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : (presc_q + PRESC_ONE);
            end else begin
                presc_d = presc_q;
            end

            if (tick_s) begin
                sec_tick_d = 1'b1;
                if (seconds_q == 6'd59) begin
                    seconds_d = 6'd0;
                    if (minutes_q == 6'd59) begin
                        minutes_d = 6'd0;
                        if (hours_q == 5'd23) begin
                            hours_d    = 5'd0;
                            day_tick_d = 1'b1;
                        end else begin
                            hours_d = hours_q + 5'd1;
                        end
                    end else begin
                        minutes_d = minutes_q + 6'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 6'd1;
                end
                // Alarm only on a tick-driven arrival at hh:mm:00.
                alarm_hit_d = alarm_en && alarm_range_s
                              && (hours_d == alarm_hours)
                              && (minutes_d == alarm_minutes)
                              && (seconds_d == 6'd0);
            end else begin
                sec_tick_d = 1'b0;
            end
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            seconds_q   <= 6'd0;
            minutes_q   <= 6'd0;
            hours_q     <= 5'd0;
            sec_tick_q  <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            seconds_q   <= seconds_d;
            minutes_q   <= minutes_d;
            hours_q     <= hours_d;
            sec_tick_q  <= sec_tick_d;
            day_tick_q  <= day_tick_d;
            alarm_hit_q <= alarm_hit_d;
            set_err_q   <= set_err_d;
        end
    end

    // 12 h view derived from the registered hour.
    always_comb begin
        hours_m12_s = hours_q - 5'd12;
        if (hours_q == 5'd0) begin
            hours12 = 4'd12;
            pm      = 1'b0;
        end else if (hours_q < 5'd12) begin
            hours12 = hours_q[3:0];
            pm      = 1'b0;
        end else if (hours_q == 5'd12) begin
            hours12 = 4'd12;
            pm      = 1'b1;
        end else begin
            hours12 = hours_m12_s[3:0];
            pm      = 1'b1;
        end
    end

    assign seconds   = seconds_q;
    assign minutes   = minutes_q;
    assign hours     = hours_q;
    assign sec_tick  = sec_tick_q;
    assign day_tick  = day_tick_q;
    assign alarm_hit = alarm_hit_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_rtc_timekeeper
// Self-checking bench for rtc_timekeeper (CLK_FREQ_HZ = 4). A reference model
// keeps the time as a plain seconds-of-day count plus a cycle phase; a compare
// process checks every output against it on each falling edge. Directed
// sequences pin literal values, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_rtc_timekeeper;

    localparam int FREQ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = 5'd0;
    logic [5:0] set_minutes = 6'd0;
    logic [5:0] set_seconds = 6'd0;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hours = 5'd0;
    logic [5:0] alarm_minutes = 6'd0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [3:0] hours12;
    logic       pm;
    logic       sec_tick;
    logic       day_tick;
    logic       alarm_hit;
    logic       set_err;

    int n_tests = 0;
    int n_fail  = 0;

    rtc_timekeeper #(.CLK_FREQ_HZ(FREQ)) dut (
        .clk(clk), .reset(reset), .run(run), .set_en(set_en),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .seconds(seconds), .minutes(minutes), .hours(hours), .hours12(hours12),
        .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick), .alarm_hit(alarm_hit),
        .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time of day as seconds since midnight.
    int m_tod = 0;
    int m_phase = 0;
    bit m_valid = 1'b0;
    bit m_sec = 1'b0, m_day = 1'b0, m_alarm = 1'b0, m_err = 1'b0;
    bit m_tick, m_load;

    always @(posedge clk) begin
        if (reset) begin
            m_tod = 0; m_phase = 0; m_valid = 1'b1;
            m_sec = 1'b0; m_day = 1'b0; m_alarm = 1'b0; m_err = 1'b0;
        end else if (m_valid) begin
            m_tick = run && (m_phase == FREQ - 1);
            m_load = set_en && (int'(set_hours) < 24) && (int'(set_minutes) < 60)
                     && (int'(set_seconds) < 60);
            m_sec = 1'b0; m_day = 1'b0; m_alarm = 1'b0; m_err = 1'b0;
            if (m_load) begin
                m_tod   = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                m_phase = 0;
            end else begin
                m_err = set_en;
                if (run) m_phase = (m_phase + 1) % FREQ;
                if (m_tick) begin
                    m_tod   = (m_tod + 1) % 86400;
                    m_sec   = 1'b1;
                    m_day   = (m_tod == 0);
                    m_alarm = alarm_en && (int'(alarm_hours) < 24) && (int'(alarm_minutes) < 60)
                              && (m_tod == int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60);
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("seconds",   32'(seconds),   32'(m_tod % 60));
            check("minutes",   32'(minutes),   32'((m_tod / 60) % 60));
            check("hours",     32'(hours),     32'(m_tod / 3600));
            check("hours12",   32'(hours12),   32'(((m_tod / 3600) % 12 == 0) ? 12 : (m_tod / 3600) % 12));
            check("pm",        32'(pm),        32'(m_tod / 3600 >= 12));
            check("sec_tick",  32'(sec_tick),  32'(m_sec));
            check("day_tick",  32'(day_tick),  32'(m_day));
            check("alarm_hit", 32'(alarm_hit), 32'(m_alarm));
            check("set_err",   32'(set_err),   32'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_en = 1'b1; set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        step(1);
        set_en = 1'b0;
    endtask

    int h_r, m_r;

    initial begin
        // Reset state.
        step(1);
        check("rst_seconds", 32'(seconds), 32'd0);
        check("rst_hours", 32'(hours), 32'd0);
        check("rst_sec_tick", 32'(sec_tick), 32'd0);
        reset = 1'b0; run = 1'b1;

        // 16 running cycles: a tick every 4th cycle.
        for (int i = 0; i < 16; i++) begin
            step(1);
            check("run16_tick", 32'(sec_tick), 32'(i % 4 == 3));
        end
        check("run16_seconds", 32'(seconds), 32'd4);
        check("run16_minutes", 32'(minutes), 32'd0);

        // Set 23:59:58 and roll over midnight.
        do_set(23, 59, 58);
        check("set_hours", 32'(hours), 32'd23);
        check("set_seconds", 32'(seconds), 32'd58);
        check("set_no_tick", 32'(sec_tick), 32'd0);
        step(4);
        check("pre_wrap_sec", 32'(seconds), 32'd59);
        step(4);
        check("wrap_hours", 32'(hours), 32'd0);
        check("wrap_seconds", 32'(seconds), 32'd0);
        check("wrap_sec_tick", 32'(sec_tick), 32'd1);
        check("wrap_day_tick", 32'(day_tick), 32'd1);
        check("wrap_hours12", 32'(hours12), 32'd12);
        check("wrap_pm", 32'(pm), 32'd0);

        // Invalid sets leave the time alone.
        run = 1'b0;
        do_set(5, 60, 0);
        check("bad_min_err", 32'(set_err), 32'd1);
        check("bad_min_hours", 32'(hours), 32'd0);
        step(1);
        check("err_one_cycle", 32'(set_err), 32'd0);
        do_set(24, 0, 0);
        check("bad_hr_err", 32'(set_err), 32'd1);
        check("bad_hr_hours", 32'(hours), 32'd0);

        // Alarm at 07:00.
        alarm_en = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd0;
        do_set(6, 59, 59);
        run = 1'b1;
        step(4);
        check("alarm_hours", 32'(hours), 32'd7);
        check("alarm_hit", 32'(alarm_hit), 32'd1);
        step(1);
        check("alarm_one_cycle", 32'(alarm_hit), 32'd0);
        run = 1'b0; alarm_en = 1'b0;
        do_set(6, 59, 59);
        run = 1'b1;
        step(4);
        check("alarm_dis_hours", 32'(hours), 32'd7);
        check("alarm_dis_hit", 32'(alarm_hit), 32'd0);
        run = 1'b0; alarm_en = 1'b1;
        do_set(7, 0, 0);
        check("alarm_set_hit", 32'(alarm_hit), 32'd0);

        // Pause keeps the partial second.
        do_set(0, 0, 0);
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin step(1); check("pause_pre", 32'(sec_tick), 32'd0); end
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin step(1); check("pause_hold", 32'(sec_tick), 32'd0); end
        run = 1'b1;
        step(1);
        check("resume_1", 32'(sec_tick), 32'd0);
        step(1);
        check("resume_2", 32'(sec_tick), 32'd1);
        check("resume_sec", 32'(seconds), 32'd1);

        // Valid set coincident with a tick.
        step(3);
        do_set(10, 20, 30);
        check("coinc_sec", 32'(seconds), 32'd30);
        check("coinc_min", 32'(minutes), 32'd20);
        check("coinc_no_tick", 32'(sec_tick), 32'd0);

        // Reset in mid-second.
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_sec", 32'(seconds), 32'd0);
        check("mid_rst_hours", 32'(hours), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("post_rst_tick", 32'(sec_tick), 32'(i == 3));
        end

        // 12 h view of 13:00.
        run = 1'b0;
        do_set(13, 0, 0);
        check("h13_hours12", 32'(hours12), 32'd1);
        check("h13_pm", 32'(pm), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            run    = ($urandom_range(0, 7) != 0);
            set_en = ($urandom_range(0, 31) == 0);
            if (set_en) begin
                case ($urandom_range(0, 3))
                    0: begin
                        set_hours = 5'd23; set_minutes = 6'd59;
                        set_seconds = 6'($urandom_range(56, 59));
                    end
                    1: begin
                        h_r = int'($urandom_range(0, 23));
                        m_r = int'($urandom_range(0, 58));
                        set_hours = 5'(h_r); set_minutes = 6'(m_r);
                        set_seconds = 6'($urandom_range(55, 59));
                        alarm_hours = 5'(h_r); alarm_minutes = 6'(m_r + 1);
                        alarm_en = 1'($urandom_range(0, 1));
                    end
                    default: begin
                        set_hours   = 5'($urandom_range(0, 25));
                        set_minutes = 6'($urandom_range(0, 61));
                        set_seconds = 6'($urandom_range(0, 61));
                    end
                endcase
            end
            if ($urandom_range(0, 99) == 0) begin
                alarm_hours   = 5'($urandom_range(0, 31));
                alarm_minutes = 6'($urandom_range(0, 63));
            end
            step(1);
        end
        reset = 1'b0; set_en = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
